dpram_bank_arb: RTL and testbench

- Parametrised, registered successor to the 2-to-4 memory bank decoder for the banked dual-port RAM.
- Decodes a write-port address and a read-port address into one-hot bank selects plus row addresses, one per port.
- Detects same-bank write/read collisions and resolves them with round-robin priority over a valid/ready handshake.
- Counts collisions for debug; sits between the port front-ends and the RAM bank array.

---
 rtl/dpram_bank_arb.sv | 118 +++++++++++
 tb/tb_dpram_bank_arb.sv | 138 +++++++++++++
 2 files changed

// File: rtl/dpram_bank_arb.sv
// dpram_bank_arb
// Bank decoder and collision arbiter for the banked dual-port RAM.
// Splits the write-port and read-port addresses into a bank index (top
// BANK_BITS bits) and a row (remaining bits). It resolves same-bank
// write/read collisions with a one-bit round-robin priority, and presents
// registered one-hot bank enables and row addresses one cycle after acceptance.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   wr_req, wr_addr       write-port request and address
//   rd_req, rd_addr       read-port request and address
//   wr_ready, rd_ready    combinational accept (access taken when req && ready)
//   wr_bank_sel, wr_row   registered one-hot write bank enable and row
//   rd_bank_sel, rd_row   registered one-hot read bank enable and row
//   conflict_cnt          saturating count of collision cycles
module dpram_bank_arb #(
  parameter int ADDR_WIDTH = 8,
  parameter int BANK_BITS  = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 wr_req,
  input  logic [ADDR_WIDTH-1:0]                wr_addr,
  input  logic                                 rd_req,
  input  logic [ADDR_WIDTH-1:0]                rd_addr,
  output logic                                 wr_ready,
  output logic                                 rd_ready,
  output logic [(2**BANK_BITS)-1:0]            wr_bank_sel,
  output logic [ADDR_WIDTH-BANK_BITS-1:0]      wr_row,
  output logic [(2**BANK_BITS)-1:0]            rd_bank_sel,
  output logic [ADDR_WIDTH-BANK_BITS-1:0]      rd_row,
  output logic [CNT_WIDTH-1:0]                 conflict_cnt
);

  localparam int NUM_BANKS = 2**BANK_BITS;
  localparam int ROW_WIDTH = ADDR_WIDTH - BANK_BITS;

  function automatic logic [NUM_BANKS-1:0] bank_onehot(input logic [BANK_BITS-1:0] b);
    logic [NUM_BANKS-1:0] oh;
    oh = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      oh[i] = (b == BANK_BITS'(i));
    end
    return oh;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  logic [BANK_BITS-1:0] wr_bank, rd_bank;
  logic                 conflict;
  logic                 wr_acc, rd_acc;

  logic                 prio_q, prio_d;
  logic [NUM_BANKS-1:0] wr_sel_q, wr_sel_d, rd_sel_q, rd_sel_d;
  logic [ROW_WIDTH-1:0] wr_row_q, wr_row_d, rd_row_q, rd_row_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  assign wr_bank  = wr_addr[ADDR_WIDTH-1 -: BANK_BITS];
  assign rd_bank  = rd_addr[ADDR_WIDTH-1 -: BANK_BITS];
  assign conflict = wr_req && rd_req && (wr_bank == rd_bank);

  // prio_q == 0 favours the write port on a collision, 1 favours the read port.
  // Ready does not depend on req outside a collision, and is held low in reset.
  assign wr_ready = rst_n && (!conflict || !prio_q);
  assign rd_ready = rst_n && (!conflict ||  prio_q);
  assign wr_acc   = wr_req && wr_ready;
  assign rd_acc   = rd_req && rd_ready;

  always_comb begin
    prio_d   = prio_q;
    wr_sel_d = '0;
    rd_sel_d = '0;
    wr_row_d = wr_row_q;
    rd_row_d = rd_row_q;
    cnt_d    = cnt_q;
    if (wr_acc) begin
      wr_sel_d = bank_onehot(wr_bank);
      wr_row_d = wr_addr[ROW_WIDTH-1:0];
    end
    if (rd_acc) begin
      rd_sel_d = bank_onehot(rd_bank);
      rd_row_d = rd_addr[ROW_WIDTH-1:0];
    end
    // The side that lost this collision owns the next one.
    if (conflict) begin
      prio_d = !prio_q;
      cnt_d  = sat_inc(cnt_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio_q   <= 1'b0;
      wr_sel_q <= '0;
      rd_sel_q <= '0;
      wr_row_q <= '0;
      rd_row_q <= '0;
      cnt_q    <= '0;
    end else begin
      prio_q   <= prio_d;
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
      wr_row_q <= wr_row_d;
      rd_row_q <= rd_row_d;
      cnt_q    <= cnt_d;
    end
  end

  assign wr_bank_sel  = wr_sel_q;
  assign wr_row       = wr_row_q;
  assign rd_bank_sel  = rd_sel_q;
  assign rd_row       = rd_row_q;
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_dpram_bank_arb.sv
// Scoreboard bench for dpram_bank_arb (ADDR_WIDTH=8, BANK_BITS=2, CNT_WIDTH=4).
// The driver applies one directed vector per cycle, checks the combinational
// ready outputs, and queues the registered outputs expected after the next edge.
// The monitor pops one entry per rising edge and compares.
module tb_dpram_bank_arb;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_req = 1'b0, rd_req = 1'b0;
  logic [7:0]    wr_addr = '0, rd_addr = '0;
  logic          wr_ready, rd_ready;
  logic [3:0]    wr_bank_sel, rd_bank_sel;
  logic [5:0]    wr_row, rd_row;
  logic [CW-1:0] conflict_cnt;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    int            id;
    logic [3:0]    ws;
    logic [5:0]    wrow;
    logic [3:0]    rs;
    logic [5:0]    rrow;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t q[$];

  dpram_bank_arb #(.ADDR_WIDTH(8), .BANK_BITS(2), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_req(wr_req), .wr_addr(wr_addr),
    .rd_req(rd_req), .rd_addr(rd_addr),
    .wr_ready(wr_ready), .rd_ready(rd_ready),
    .wr_bank_sel(wr_bank_sel), .wr_row(wr_row),
    .rd_bank_sel(rd_bank_sel), .rd_row(rd_row),
    .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  task automatic step(input logic rst, input logic wq, input logic [7:0] wa,
                      input logic rq, input logic [7:0] ra,
                      input logic ewr, input logic err,
                      input logic [3:0] ews, input logic [5:0] ewrow,
                      input logic [3:0] ers, input logic [5:0] errow,
                      input logic [CW-1:0] ec, input int id);
    exp_t e;
    @(negedge clk);
    rst_n = rst; wr_req = wq; wr_addr = wa; rd_req = rq; rd_addr = ra;
    #1;
    tests++;
    if (wr_ready !== ewr || rd_ready !== err) begin
      fails++;
      $display("FAIL ready[%0d]: got wr=%b rd=%b, want wr=%b rd=%b",
               id, wr_ready, rd_ready, ewr, err);
    end
    e.id = id; e.ws = ews; e.wrow = ewrow; e.rs = ers; e.rrow = errow; e.cnt = ec;
    q.push_back(e);
  endtask

  // Monitor: every edge that follows a driven cycle produces one set of outputs.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        tests++;
        if (wr_bank_sel !== e.ws || wr_row !== e.wrow || rd_bank_sel !== e.rs ||
            rd_row !== e.rrow || conflict_cnt !== e.cnt) begin
          fails++;
          $display("FAIL outputs[%0d]: got ws=%b wrow=%h rs=%b rrow=%h cnt=%0d, want ws=%b wrow=%h rs=%b rrow=%h cnt=%0d",
                   e.id, wr_bank_sel, wr_row, rd_bank_sel, rd_row, conflict_cnt,
                   e.ws, e.wrow, e.rs, e.rrow, e.cnt);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, tests=%0d", tests);
    $fatal(1, "timeout");
  end

  initial begin
    logic [CW-1:0] c;
    // Reset held for two cycles: readies forced low, outputs cleared.
    step(0, 0, 8'h00, 0, 8'h00, 0, 0, 4'b0000, 6'h00, 4'b0000, 6'h00, 0, 1);
    step(0, 0, 8'h00, 0, 8'h00, 0, 0, 4'b0000, 6'h00, 4'b0000, 6'h00, 0, 2);
    step(1, 0, 8'h00, 0, 8'h00, 1, 1, 4'b0000, 6'h00, 4'b0000, 6'h00, 0, 3);
    // Write-port decode sweep, back to back.
    step(1, 1, 8'h00, 0, 8'h00, 1, 1, 4'b0001, 6'h00, 4'b0000, 6'h00, 0, 10);
    step(1, 1, 8'h40, 0, 8'h00, 1, 1, 4'b0010, 6'h00, 4'b0000, 6'h00, 0, 11);
    step(1, 1, 8'h80, 0, 8'h00, 1, 1, 4'b0100, 6'h00, 4'b0000, 6'h00, 0, 12);
    step(1, 1, 8'hC5, 0, 8'h00, 1, 1, 4'b1000, 6'h05, 4'b0000, 6'h00, 0, 13);
    // Read-port decode sweep; write row holds 05.
    step(1, 0, 8'h00, 1, 8'h00, 1, 1, 4'b0000, 6'h05, 4'b0001, 6'h00, 0, 20);
    step(1, 0, 8'h00, 1, 8'h40, 1, 1, 4'b0000, 6'h05, 4'b0010, 6'h00, 0, 21);
    step(1, 0, 8'h00, 1, 8'h80, 1, 1, 4'b0000, 6'h05, 4'b0100, 6'h00, 0, 22);
    step(1, 0, 8'h00, 1, 8'hC5, 1, 1, 4'b0000, 6'h05, 4'b1000, 6'h05, 0, 23);
    // Different banks: both accepted, no conflict counted.
    step(1, 1, 8'h12, 1, 8'hA3, 1, 1, 4'b0001, 6'h12, 4'b0100, 6'h23, 0, 30);
    // Collision on bank 1: write first, then read.
    step(1, 1, 8'h41, 1, 8'h7F, 1, 0, 4'b0010, 6'h01, 4'b0000, 6'h23, 1, 40);
    step(1, 1, 8'h41, 1, 8'h7F, 0, 1, 4'b0000, 6'h01, 4'b0010, 6'h3F, 2, 41);
    step(1, 0, 8'h41, 0, 8'h7F, 1, 1, 4'b0000, 6'h01, 4'b0000, 6'h3F, 2, 42);
    // 20 more collisions: grants alternate, counter saturates at 15.
    for (int k = 1; k <= 20; k++) begin
      c = (2 + k > 15) ? CW'(15) : CW'(2 + k);
      if (k % 2 == 1)
        step(1, 1, 8'h41, 1, 8'h7F, 1, 0, 4'b0010, 6'h01, 4'b0000, 6'h3F, c, 100 + k);
      else
        step(1, 1, 8'h41, 1, 8'h7F, 0, 1, 4'b0000, 6'h01, 4'b0010, 6'h3F, c, 100 + k);
    end
    step(1, 0, 8'h41, 0, 8'h7F, 1, 1, 4'b0000, 6'h01, 4'b0000, 6'h3F, 15, 130);
    // Read loses, then reset with both requests still held.
    step(1, 1, 8'h41, 1, 8'h7F, 1, 0, 4'b0010, 6'h01, 4'b0000, 6'h3F, 15, 140);
    step(0, 1, 8'h41, 1, 8'h7F, 0, 0, 4'b0000, 6'h00, 4'b0000, 6'h00, 0, 141);
    // Priority is back to write after reset.
    step(1, 1, 8'h41, 1, 8'h7F, 1, 0, 4'b0010, 6'h01, 4'b0000, 6'h00, 1, 142);
    step(1, 0, 8'h00, 0, 8'h00, 1, 1, 4'b0000, 6'h01, 4'b0000, 6'h00, 1, 143);
    @(posedge clk);
    #2;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expected entries left, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
